// File: rtl/bus_pkg.sv
// Shared types for the system-bus arbiter between the 6502 core and the DMA port.
package bus_pkg;

  typedef enum logic [1:0] {
    ARB_CPU,
    ARB_DMA,
    ARB_RET
  } arb_state_t;

  // Width of a counter that must hold 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: the 6502 core owns the bus by default; DMA is granted
// only on opcode-fetch (SYNC) cycles and holds the core off through READY.
module mem_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int CPU_MIN   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rw,
  input  logic              cpu_sync,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BEAT_W  = cnt_w(MAX_BURST);
  localparam int GUARD_W = cnt_w(CPU_MIN);
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(CPU_MIN);

  arb_state_t         state, state_nxt;
  logic [BEAT_W-1:0]  beat, beat_nxt;
  logic [GUARD_W-1:0] guard, guard_nxt;
  logic               beat_en;

  logic               cpu_own_p1;
  logic               rvalid_p1;
  logic [DATA_W-1:0]  hold_p1;

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    guard_nxt = guard;
    beat_en   = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_rw    = cpu_rw;
    cpu_ready = 1'b1;
    dma_gnt   = 1'b0;

    case (state)
      ARB_CPU: begin
        if (dma_req && cpu_sync && (guard == '0)) begin
          state_nxt = ARB_DMA;
          beat_nxt  = '0;
        end else if (cpu_sync && (guard != '0)) begin
          guard_nxt = guard - 1'b1;
        end
      end
      ARB_DMA: begin
        cpu_ready = 1'b0;
        dma_gnt   = 1'b1;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_rw    = !(dma_req && dma_we);
        beat_en   = dma_req;
        if (!dma_req) begin
          state_nxt = ARB_RET;
        end else begin
          beat_nxt = beat + 1'b1;
          if (beat == BEAT_LAST) state_nxt = ARB_RET;
        end
      end
      ARB_RET: begin
        // Re-present the stalled core address as a read so data is ready when READY returns.
        cpu_ready = 1'b0;
        mem_rw    = 1'b1;
        guard_nxt = GUARD_INIT;
        state_nxt = ARB_CPU;
      end
      default: state_nxt = ARB_CPU;
    endcase

    // While reset is held the bus belongs to the core and no write may reach RAM.
    if (i_rst) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_rw    = 1'b1;
      cpu_ready = 1'b1;
      dma_gnt   = 1'b0;
      beat_en   = 1'b0;
    end
  end

  // Stage p1: one cycle after the RAM address, when its read data returns
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ARB_CPU;
      beat       <= '0;
      guard      <= '0;
      cpu_own_p1 <= 1'b0;
      rvalid_p1  <= 1'b0;
      hold_p1    <= '0;
    end else begin
      state      <= state_nxt;
      beat       <= beat_nxt;
      guard      <= guard_nxt;
      cpu_own_p1 <= (state != ARB_DMA);
      rvalid_p1  <= beat_en && !dma_we;
      if (cpu_own_p1) hold_p1 <= mem_rdata;
    end
  end

  assign cpu_rdata  = cpu_own_p1 ? mem_rdata : hold_p1;
  assign dma_rvalid = rvalid_p1;
  assign dma_rdata  = mem_rdata;

endmodule
